// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and arming FSM encoding for the GPIO register block
package gpio_pkg;
   localparam logic [31:0] GPIO_ADDR  = 32'h0000ABCD;
   localparam int          CMD_BIT    = 31;
   localparam int          TOGGLE_BIT = 30;
   localparam int          FLAG_LSB   = 24;
   localparam int          IN_LSB     = 16;
   localparam int          OUT_LSB    = 0;
   typedef enum logic {DISARMED = 1'b0, ARMED = 1'b1} arm_state_t;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: STAGES-deep multi-bit input synchronizer, async reset to 0
module gpio_sync
   import gpio_pkg::*;
#(
   parameter int W      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [STAGES-1:0][W-1:0] chain;
   // shift the raw pins through the flop chain, oldest sample on top
   always_ff @(posedge clk or posedge reset)
      if (reset) chain <= '0;
      else       chain <= {chain[STAGES-2:0], d};
   assign q = chain[STAGES-1];
endmodule

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO block (output latch, synced edge flags, irq); macro GPIO_TOGGLE_EN adds XOR-toggle writes
module gpio_port
   import gpio_pkg::*;
#(
   parameter int OUT_W       = 16,
   parameter int IN_W        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             GPIO_W,
   input  logic [31:0]      WriteData,
   input  logic [IN_W-1:0]  GPIO_in,
   output logic [OUT_W-1:0] GPIO_out,
   output logic [31:0]      GPIO_rdata,
   output logic             GPIO_irq
);
   localparam int CW = $clog2(SYNC_STAGES + 1);
   logic [OUT_W-1:0] out_reg, out_nxt;
   logic [IN_W-1:0]  in_sync, prev, flags, rise, clr;
   logic [CW-1:0]    arm_cnt;
   arm_state_t       state;
   logic             toggle;
   logic             unused_wd;
   gpio_sync #(.W(IN_W), .STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (GPIO_in),
      .q     (in_sync)
   );
`ifdef GPIO_TOGGLE_EN
   assign toggle = WriteData[TOGGLE_BIT];
`else
   assign toggle = 1'b0;
`endif
   assign unused_wd = ^WriteData;
   // edge detect is gated until the synchronizer has flushed its reset contents
   always_comb begin
      rise    = (state == ARMED) ? in_sync & ~prev : '0;
      clr     = (GPIO_W && WriteData[CMD_BIT]) ? WriteData[IN_W-1:0] : '0;
      out_nxt = toggle ? out_reg ^ WriteData[OUT_W-1:0] : WriteData[OUT_W-1:0];
   end
   // output latch, previous-sample register and sticky flags (a new rise beats a clear)
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         out_reg <= '0;
         prev    <= '0;
         flags   <= '0;
      end else begin
         if (GPIO_W && !WriteData[CMD_BIT]) out_reg <= out_nxt;
         prev  <= in_sync;
         flags <= (flags & ~clr) | rise;
      end
   // arming FSM: count SYNC_STAGES cycles after reset release, then stay armed
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= DISARMED;
         arm_cnt <= '0;
      end else if (state == DISARMED) begin
         if (arm_cnt == CW'(SYNC_STAGES)) state <= ARMED;
         else arm_cnt <= arm_cnt + 1'b1;
      end
   assign GPIO_out   = out_reg;
   assign GPIO_irq   = |flags;
   assign GPIO_rdata = (32'(flags) << (OUT_W + IN_W)) | (32'(in_sync) << OUT_W) | 32'(out_reg);
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed and randomized checks of gpio_port against a behavioural model
module tb_gpio_port;
   localparam int S = 2;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        GPIO_W = 1'b0;
   logic [31:0] WriteData = '0;
   logic [7:0]  GPIO_in = 8'hFF;
   logic [15:0] GPIO_out;
   logic [31:0] GPIO_rdata;
   logic        GPIO_irq;
   int vectors = 0, errors = 0;
   bit done = 0;
   gpio_port dut (
      .clk        (clk),
      .reset      (reset),
      .GPIO_W     (GPIO_W),
      .WriteData  (WriteData),
      .GPIO_in    (GPIO_in),
      .GPIO_out   (GPIO_out),
      .GPIO_rdata (GPIO_rdata),
      .GPIO_irq   (GPIO_irq)
   );
   always #5 clk = ~clk;
   // model: samp[j] is the pin value sampled at edge j+1 after reset release
   logic [7:0]  samp[$];
   logic [15:0] m_out = '0;
   logic [7:0]  m_flags = '0;
   logic [7:0]  cur, prv, rise, clr;
   bit          m_toggle;
   int          n;
   function automatic logic [7:0] sync_at(int k);
      int idx = k - S;
      return (idx < 0) ? 8'h00 : samp[idx];
   endfunction
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_out = '0;
         m_flags = '0;
         samp.delete();
      end else begin
         n = samp.size();
         cur = sync_at(n);
         prv = sync_at(n - 1);
         rise = (n >= S + 1) ? (cur & ~prv) : 8'h00;
         clr = (GPIO_W && WriteData[31]) ? WriteData[7:0] : 8'h00;
         m_flags = (m_flags & ~clr) | rise;
`ifdef GPIO_TOGGLE_EN
         m_toggle = WriteData[30];
`else
         m_toggle = 1'b0;
`endif
         if (GPIO_W && !WriteData[31]) m_out = m_toggle ? (m_out ^ WriteData[15:0]) : WriteData[15:0];
         samp.push_back(GPIO_in);
      end
   end
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk) if (!done) begin
      chk("out", 32'(GPIO_out), 32'(m_out));
      chk("irq", 32'(GPIO_irq), 32'(|m_flags));
      chk("rdata", GPIO_rdata, {m_flags, sync_at(samp.size()), m_out});
   end
   task automatic cyc(int k);
      repeat (k) @(negedge clk);
      #1;
   endtask
   task automatic wr(logic [31:0] d);
      GPIO_W = 1'b1;
      WriteData = d;
      cyc(1);
      GPIO_W = 1'b0;
   endtask
   initial begin
      #3;
      chk("rst_rdata", GPIO_rdata, 32'h0);
      chk("rst_out", 32'(GPIO_out), 32'h0);
      chk("rst_irq", 32'(GPIO_irq), 32'h0);
      cyc(2);
      reset = 1'b0;
      cyc(2);
      chk("sync_ff", 32'(GPIO_rdata[23:16]), 32'hFF);
      chk("m_sync_ff", 32'(sync_at(samp.size())), 32'hFF);
      cyc(10);
      chk("no_spurious_irq", 32'(GPIO_irq), 32'h0);
      chk("no_spurious_flags", 32'(GPIO_rdata[31:24]), 32'h0);
      GPIO_in = 8'h00;
      cyc(5);
      wr(32'h0000A5A5);
      chk("wr_out", 32'(GPIO_out), 32'hA5A5);
      chk("wr_rdata", 32'(GPIO_rdata[15:0]), 32'hA5A5);
      WriteData = 32'h0000FFFF;
      cyc(1);
      chk("no_wr", 32'(GPIO_out), 32'hA5A5);
      GPIO_in = 8'h08;
      cyc(2);
      chk("irq_early", 32'(GPIO_irq), 32'h0);
      cyc(1);
      chk("flag3", 32'(GPIO_rdata[31:24]), 32'h08);
      chk("m_flag3", 32'(m_flags), 32'h08);
      chk("irq3", 32'(GPIO_irq), 32'h1);
      wr(32'h80000008);
      chk("w1c_flags", 32'(GPIO_rdata[31:24]), 32'h00);
      chk("w1c_irq", 32'(GPIO_irq), 32'h0);
      GPIO_in = 8'h0C;
      cyc(2);
      wr(32'h80000004);
      chk("set_wins", 32'(GPIO_rdata[31:24]), 32'h04);
      wr(32'h00001234);
      GPIO_in = 8'h00;
      cyc(4);
      GPIO_in = 8'h0F;
      cyc(4);
      chk("pre_rst_flags", 32'(GPIO_rdata[31:24]), 32'h0F);
      chk("pre_rst_out", 32'(GPIO_out), 32'h1234);
      #1 reset = 1'b1;
      #1;
      chk("async_out", 32'(GPIO_out), 32'h0);
      chk("async_irq", 32'(GPIO_irq), 32'h0);
      chk("async_rdata", GPIO_rdata, 32'h0);
      GPIO_W = 1'b1;
      WriteData = 32'h000000FF;
      @(negedge clk);
      #1 reset = 1'b0;
      cyc(1);
      GPIO_W = 1'b0;
      chk("wr_at_release", 32'(GPIO_out), 32'h00FF);
      wr(32'h40000F0F);
`ifdef GPIO_TOGGLE_EN
      chk("toggle", 32'(GPIO_out), 32'h0FF0);
`else
      chk("no_toggle", 32'(GPIO_out), 32'h0F0F);
`endif
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         #1;
         reset = ($urandom_range(0, 199) == 0);
         GPIO_in = GPIO_in ^ 8'($urandom & $urandom & $urandom);
         GPIO_W = ($urandom_range(0, 9) < 3);
         WriteData = $urandom;
      end
      reset = 1'b0;
      GPIO_W = 1'b0;
      cyc(2);
      done = 1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Memory-mapped GPIO register block. Sits directly downstream of the store-address decoder that asserts GPIO_W for a store to 32'h0000ABCD.
- On each GPIO_W strobe it either updates a latched output register or clears sticky input-edge flags.
- Continuously synchronizes external input pins, detects rising edges and raises an interrupt request.
- Provides a combinational readback word for the load path.

Parameters:
- OUT_W, 16: width of the output register / GPIO_out pins.
- IN_W, 8: width of GPIO_in pins and edge flags.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizer (legal range 2..4).
- Constraint: OUT_W + 2*IN_W <= 32.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- GPIO_W  in  1  write strobe from the decoder; one cycle per store.
- WriteData  in  32  store data (rs2 value) accompanying GPIO_W.
- GPIO_in  in  IN_W  asynchronous external input pins.
- GPIO_out  out  OUT_W  registered output pins.
- GPIO_rdata  out  32  readback word for the load path.
- GPIO_irq  out  1  OR of all edge flags.

Behaviour:
- Reset (async, active-high) forces: out_reg=0, sync chain=0, prev=0, flags=0, arm_cnt=0, armed=0. Consequently GPIO_out=0, GPIO_irq=0 and GPIO_rdata=0 during reset.
- Write decode, on a clk edge with GPIO_W=1:
  - WriteData[31]=0: out_reg <= WriteData[OUT_W-1:0]. GPIO_out changes after that same edge (1-cycle latency).
  - WriteData[31]=1: write-one-to-clear, flags <= flags & ~WriteData[IN_W-1:0]. out_reg is unchanged.
  - GPIO_W=0: no state change from the write path.
- Input path:
  - GPIO_in passes through SYNC_STAGES flops to produce in_sync; prev <= in_sync every cycle.
  - A pin change appears in in_sync SYNC_STAGES edges later.
- Edge detect: rise[i] = in_sync[i] & ~prev[i] & armed. When rise[i] is set, flags[i] sets on the next edge, i.e. SYNC_STAGES+1 edges after the pin change.
- Arming FSM (2 states):
  - DISARMED: arm_cnt increments each cycle. When arm_cnt == SYNC_STAGES, go to ARMED on the next edge.
  - ARMED: terminal until reset.
  - Purpose: pins already high at reset release do not create spurious flags.
  - arm_cnt is wide enough for SYNC_STAGES and saturates.
- Simultaneous W1C clear and new rise on the same bit in the same cycle: set wins, and the flag stays 1.
- Clearing a bit that is already 0 has no effect.
- GPIO_irq = |flags. It is registered-derived, so it has no combinational path from GPIO_in.
- GPIO_rdata is combinational from registers:
  - [31:24] flags
  - [23:16] in_sync
  - [15:0] out_reg
  - Fields are zero-extended at defaults; for other widths, fields are packed LSB-first at offsets 0, OUT_W, OUT_W+IN_W and unused bits read 0.
- Reset asserted mid-operation:
  - All state clears immediately, without waiting for clk.
  - The arming sequence restarts after release.
  - A GPIO_W asserted in the cycle reset deasserts is honoured on the first clk edge after release.

Optional Feature:
- Macro: GPIO_TOGGLE_EN.
- Defined: when WriteData[31]=0 and WriteData[30]=1, out_reg <= out_reg ^ WriteData[OUT_W-1:0]. This toggles the selected bits; WriteData[30]=0 keeps overwrite.
- Undefined: WriteData[30] is ignored and every bit-31=0 write is an overwrite.

Decomposition:
- Shared package gpio_pkg holds:
  - GPIO_ADDR = 32'h0000ABCD
  - CMD_BIT = 31
  - TOGGLE_BIT = 30
  - readback field offsets FLAG_LSB = 24, IN_LSB = 16, OUT_LSB = 0
  - arming FSM state encodings DISARMED = 1'b0, ARMED = 1'b1
- One sub-module, gpio_sync: a per-vector SYNC_STAGES-deep synchronizer with async reset to 0. It is instantiated once with width IN_W.

Test Plan:
- Reset release with GPIO_in=8'hFF held -> no flags ever set; GPIO_irq=0; GPIO_rdata[23:16]=8'hFF after 2 cycles.
- GPIO_W=1, WriteData=32'h0000A5A5 -> GPIO_out=16'hA5A5 after the next edge; GPIO_rdata[15:0]=16'hA5A5. With GPIO_W=0 and the same data -> no change.
- GPIO_in bit3 rises 0->1 (armed) -> flags[3]=1 and GPIO_irq=1 exactly 3 edges later. Then write 32'h80000008 -> flags[3]=0 and GPIO_irq=0 on the next edge.
- Bit2 rises in the same cycle as a W1C write 32'h80000004 -> flags[2] remains 1.
- Assert reset asynchronously mid-cycle with out_reg=16'h1234 and flags=8'h0F -> GPIO_out=0, GPIO_irq=0 and GPIO_rdata=0 before the next clk edge.
- With GPIO_TOGGLE_EN and out_reg=16'h00FF, write 32'h40000F0F -> GPIO_out=16'h0FF0. Without the macro, the same write gives GPIO_out=16'h0F0F.
